// File: rtl/pkt_ique_rd.sv
// Read side of the packet input queue: pops a length descriptor, then streams the
// matching data words out as a framed packet (sop/eop/mod) through one output register.
module pkt_ique_rd #(
    parameter int DWID = 64,
    parameter int LWID = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         desc_empty,
    input  logic [LWID-1:0]              desc_rdata,
    output logic                         desc_rd,
    input  logic                         dat_empty,
    input  logic [DWID-1:0]              dat_rdata,
    output logic                         dat_rd,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [DWID-1:0]              out_data,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [$clog2(DWID/8)-1:0]    out_mod,
    output logic                         err_len,
    output logic [31:0]                  pkt_cnt
);
    localparam int BYTES = DWID / 8;
    localparam int MODW  = $clog2(BYTES);
    localparam logic [LWID:0] ROUND = (LWID+1)'(BYTES - 1);
    localparam logic [LWID:0] ONE   = (LWID+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

    state_e            state_q, state_d;
    logic [LWID:0]     rem_q, rem_d;
    logic              first_q, first_d;
    logic [MODW-1:0]   mod_q, mod_d;
    logic              vld_q, vld_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic [MODW-1:0]   omod_q, omod_d;
    logic [DWID-1:0]   data_q, data_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              adv;
    logic [LWID:0]     words;

    // Word count is computed one bit wider so a maximal length cannot wrap.
    assign words = ({1'b0, desc_rdata} + ROUND) >> MODW;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        first_d = first_q;
        mod_d   = mod_q;
        vld_d   = vld_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        omod_d  = omod_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        desc_rd = 1'b0;
        dat_rd  = 1'b0;
        err_len = 1'b0;
        adv     = !dat_empty && (!vld_q || out_rdy);

        if (vld_q && out_rdy) begin
            vld_d  = 1'b0;
            sop_d  = 1'b0;
            eop_d  = 1'b0;
            omod_d = '0;
            if (eop_q) cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (!desc_empty) state_d = LOAD;
            end
            LOAD: begin
                desc_rd = 1'b1;
                mod_d   = desc_rdata[MODW-1:0];
                if (desc_rdata == '0) begin
                    err_len = 1'b1;
                    state_d = IDLE;
                end else begin
                    rem_d   = words;
                    first_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // A pop may replace a word being accepted this cycle, so no bubble.
                if (adv) begin
                    dat_rd  = 1'b1;
                    data_d  = dat_rdata;
                    vld_d   = 1'b1;
                    sop_d   = first_q;
                    eop_d   = (rem_q == ONE);
                    omod_d  = (rem_q == ONE) ? mod_q : '0;
                    first_d = 1'b0;
                    rem_d   = rem_q - ONE;
                    if (rem_q == ONE) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            first_q <= 1'b0;
            mod_q   <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            omod_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            mod_q   <= mod_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            omod_q  <= omod_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_sop  = sop_q;
    assign out_eop  = eop_q;
    assign out_mod  = omod_q;
    assign out_data = data_q;
    assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_pkt_ique_rd.sv
// Directed bench for pkt_ique_rd: FWFT FIFO models feed the block, a monitor records
// accepted words, and each scenario task compares against hand-computed framing.
module tb_pkt_ique_rd;
    localparam int DWID = 64;
    localparam int LWID = 16;
    localparam int MODW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            desc_empty = 1'b1;
    logic [LWID-1:0] desc_rdata = '0;
    logic            desc_rd;
    logic            dat_empty = 1'b1;
    logic [DWID-1:0] dat_rdata = '0;
    logic            dat_rd;
    logic            out_vld;
    logic            out_rdy = 1'b0;
    logic [DWID-1:0] out_data;
    logic            out_sop;
    logic            out_eop;
    logic [MODW-1:0] out_mod;
    logic            err_len;
    logic [31:0]     pkt_cnt;

    pkt_ique_rd #(.DWID(DWID), .LWID(LWID)) dut (
        .clk(clk), .rst(rst),
        .desc_empty(desc_empty), .desc_rdata(desc_rdata), .desc_rd(desc_rd),
        .dat_empty(dat_empty), .dat_rdata(dat_rdata), .dat_rd(dat_rd),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_mod(out_mod),
        .err_len(err_len), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models and ready pattern
    logic [LWID-1:0] dq[$];
    logic [DWID-1:0] xq[$];
    int  hold = 0, pops = 0, stall_at = -1;
    bit  rdy_mode = 1'b0, rdy_val = 1'b1;
    bit  pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        bit pd, px;
        forever begin
            @(negedge clk);
            pd = desc_rd;
            px = dat_rd;
            @(posedge clk);
            #1;
            if (pd && dq.size() > 0) void'(dq.pop_front());
            if (hold > 0) hold--;
            if (px && xq.size() > 0) begin
                void'(xq.pop_front());
                pops++;
                if (pops == stall_at) hold = 5;
            end
            desc_empty = (dq.size() == 0);
            desc_rdata = desc_empty ? '0 : dq[0];
            dat_empty  = (xq.size() == 0) || (hold > 0);
            dat_rdata  = (xq.size() == 0) ? '0 : xq[0];
            out_rdy    = rdy_mode ? pat[cyc % 4] : rdy_val;
        end
    end

    // Monitor: records accepted words and counts protocol events
    logic [DWID-1:0] cap_data[$];
    bit              cap_sop[$], cap_eop[$];
    logic [MODW-1:0] cap_mod[$];
    int              cap_cyc[$];
    int stab_err = 0, rd_empty_err = 0, held_err = 0, mod_err = 0;
    int err_cnt = 0, held_cyc = 0, vld_cyc = 0, fall_cyc = 0;
    logic            p_vld = 1'b0, p_rdy = 1'b0, p_sop = 1'b0, p_eop = 1'b0, p_de = 1'b1;
    logic [DWID-1:0] p_data = '0;
    logic [MODW-1:0] p_mod = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (out_vld && out_rdy) begin
                cap_data.push_back(out_data);
                cap_sop.push_back(out_sop);
                cap_eop.push_back(out_eop);
                cap_mod.push_back(out_mod);
                cap_cyc.push_back(cyc);
            end
            if (p_vld && !p_rdy && rst &&
                ({out_data, out_sop, out_eop, out_mod} !== {p_data, p_sop, p_eop, p_mod}))
                stab_err++;
            if (dat_rd && dat_empty) rd_empty_err++;
            if (dat_rd && out_vld && !out_rdy) held_err++;
            if (!out_eop && out_mod != '0) mod_err++;
            if (err_len) err_cnt++;
            if (out_vld && !out_rdy) held_cyc++;
            if (out_vld) vld_cyc++;
            if (!desc_empty && p_de) fall_cyc = cyc;
            p_vld = out_vld; p_rdy = out_rdy; p_data = out_data;
            p_sop = out_sop; p_eop = out_eop; p_mod = out_mod; p_de = desc_empty;
        end
    end

    task automatic clear_caps();
        cap_data.delete(); cap_sop.delete(); cap_eop.delete();
        cap_mod.delete(); cap_cyc.delete();
    endtask

    task automatic wait_caps(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (cap_data.size() >= n) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b expected 0", out_vld); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", out_data); end
        checks++; if ({out_sop, out_eop, out_mod} !== 5'b0) begin errors++; $display("FAIL rst_frame: got %b expected 0", {out_sop, out_eop, out_mod}); end
        checks++; if ({desc_rd, dat_rd, err_len} !== 3'b0) begin errors++; $display("FAIL rst_strobes: got %b expected 000", {desc_rd, dat_rd, err_len}); end
        checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", pkt_cnt); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        clear_caps();
        rdy_val = 1'b1;
        @(negedge clk);
        dq.push_back(16'd64);
        for (int i = 0; i < 8; i++) xq.push_back(64'(i));
        wait_caps(8, 100, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok || cap_data.size() != 8) begin errors++; $display("FAIL basic_count: got %0d expected 8", cap_data.size()); end
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({cap_data[i], cap_sop[i], cap_eop[i], cap_mod[i]} !== {64'(i), i == 0, i == 7, 3'd0}) begin
                    errors++;
                    $display("FAIL basic_word%0d: got %h/%b%b/%0d expected %h/%b%b/0", i,
                             cap_data[i], cap_sop[i], cap_eop[i], cap_mod[i], 64'(i), i == 0, i == 7);
                end
            end
            checks++; if (cap_cyc[7] - cap_cyc[0] !== 7) begin errors++; $display("FAIL basic_thruput: got %0d cycles expected 7", cap_cyc[7] - cap_cyc[0]); end
            checks++; if (cap_cyc[0] - fall_cyc !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", cap_cyc[0] - fall_cyc); end
        end
        checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL basic_pktcnt: got %0d expected 1", pkt_cnt); end
    endtask

    task automatic test_short();
        bit ok;
        clear_caps();
        @(negedge clk);
        dq.push_back(16'd1);
        dq.push_back(16'd9);
        xq.push_back(64'hAA); xq.push_back(64'h11); xq.push_back(64'h22);
        wait_caps(3, 100, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL short_count: got %0d expected 3", cap_data.size()); end
        if (ok) begin
            checks++; if ({cap_data[0], cap_sop[0], cap_eop[0], cap_mod[0]} !== {64'hAA, 1'b1, 1'b1, 3'd1}) begin errors++; $display("FAIL short_len1: got %h/%b%b/%0d expected aa/11/1", cap_data[0], cap_sop[0], cap_eop[0], cap_mod[0]); end
            checks++; if ({cap_data[1], cap_sop[1], cap_eop[1], cap_mod[1]} !== {64'h11, 1'b1, 1'b0, 3'd0}) begin errors++; $display("FAIL short_len9_w0: got %h/%b%b/%0d expected 11/10/0", cap_data[1], cap_sop[1], cap_eop[1], cap_mod[1]); end
            checks++; if ({cap_data[2], cap_sop[2], cap_eop[2], cap_mod[2]} !== {64'h22, 1'b0, 1'b1, 3'd1}) begin errors++; $display("FAIL short_len9_w1: got %h/%b%b/%0d expected 22/01/1", cap_data[2], cap_sop[2], cap_eop[2], cap_mod[2]); end
            checks++; if (cap_cyc[1] - cap_cyc[0] !== 3) begin errors++; $display("FAIL short_gap: got %0d expected 3", cap_cyc[1] - cap_cyc[0]); end
        end
        checks++; if (pkt_cnt !== 32'd3) begin errors++; $display("FAIL short_pktcnt: got %0d expected 3", pkt_cnt); end
    endtask

    task automatic test_zero_len();
        bit ok;
        int e0;
        clear_caps();
        e0 = err_cnt;
        @(negedge clk);
        dq.push_back(16'd0);
        dq.push_back(16'd16);
        xq.push_back(64'hB0); xq.push_back(64'hB1);
        wait_caps(2, 100, ok);
        repeat (4) @(negedge clk);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL zero_errlen: got %0d pulses expected 1", err_cnt - e0); end
        checks++; if (!ok || cap_data.size() != 2) begin errors++; $display("FAIL zero_count: got %0d expected 2", cap_data.size()); end
        if (ok) begin
            checks++; if ({cap_data[0], cap_sop[0], cap_eop[0], cap_mod[0]} !== {64'hB0, 1'b1, 1'b0, 3'd0}) begin errors++; $display("FAIL zero_w0: got %h/%b%b/%0d expected b0/10/0", cap_data[0], cap_sop[0], cap_eop[0], cap_mod[0]); end
            checks++; if ({cap_data[1], cap_sop[1], cap_eop[1], cap_mod[1]} !== {64'hB1, 1'b0, 1'b1, 3'd0}) begin errors++; $display("FAIL zero_w1: got %h/%b%b/%0d expected b1/01/0", cap_data[1], cap_sop[1], cap_eop[1], cap_mod[1]); end
        end
        checks++; if (pkt_cnt !== 32'd4) begin errors++; $display("FAIL zero_pktcnt: got %0d expected 4", pkt_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int s0, h0, c0;
        clear_caps();
        s0 = stab_err; h0 = held_err; c0 = held_cyc;
        rdy_mode = 1'b1;
        @(negedge clk);
        dq.push_back(16'd32);
        for (int i = 0; i < 4; i++) xq.push_back(64'hC0 + 64'(i));
        wait_caps(4, 100, ok);
        rdy_mode = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (!ok || cap_data.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", cap_data.size()); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({cap_data[i], cap_sop[i], cap_eop[i], cap_mod[i]} !== {64'hC0 + 64'(i), i == 0, i == 3, 3'd0}) begin
                    errors++;
                    $display("FAIL bp_word%0d: got %h/%b%b/%0d expected %h/%b%b/0", i,
                             cap_data[i], cap_sop[i], cap_eop[i], cap_mod[i], 64'hC0 + 64'(i), i == 0, i == 3);
                end
            end
        end
        checks++; if (held_cyc - c0 <= 0) begin errors++; $display("FAIL bp_stalled: got %0d held cycles expected >0", held_cyc - c0); end
        checks++; if (stab_err - s0 !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stab_err - s0); end
        checks++; if (held_err - h0 !== 0) begin errors++; $display("FAIL bp_pop_held: got %0d pops expected 0", held_err - h0); end
        checks++; if (pkt_cnt !== 32'd5) begin errors++; $display("FAIL bp_pktcnt: got %0d expected 5", pkt_cnt); end
    endtask

    task automatic test_underrun();
        bit ok;
        int r0, v0;
        clear_caps();
        r0 = rd_empty_err; v0 = vld_cyc;
        pops = 0;
        stall_at = 3;
        @(negedge clk);
        dq.push_back(16'd40);
        for (int i = 0; i < 5; i++) xq.push_back(64'hD0 + 64'(i));
        wait_caps(5, 100, ok);
        stall_at = -1;
        repeat (3) @(negedge clk);
        checks++; if (!ok || cap_data.size() != 5) begin errors++; $display("FAIL ur_count: got %0d expected 5", cap_data.size()); end
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if ({cap_data[i], cap_sop[i], cap_eop[i], cap_mod[i]} !== {64'hD0 + 64'(i), i == 0, i == 4, 3'd0}) begin
                    errors++;
                    $display("FAIL ur_word%0d: got %h/%b%b/%0d expected %h/%b%b/0", i,
                             cap_data[i], cap_sop[i], cap_eop[i], cap_mod[i], 64'hD0 + 64'(i), i == 0, i == 4);
                end
            end
            checks++; if (cap_cyc[3] - cap_cyc[2] !== 6) begin errors++; $display("FAIL ur_gap: got %0d expected 6", cap_cyc[3] - cap_cyc[2]); end
        end
        checks++; if (vld_cyc - v0 !== 5) begin errors++; $display("FAIL ur_vld_drop: got %0d valid cycles expected 5", vld_cyc - v0); end
        checks++; if (rd_empty_err - r0 !== 0) begin errors++; $display("FAIL ur_rd_empty: got %0d expected 0", rd_empty_err - r0); end
        checks++; if (pkt_cnt !== 32'd6) begin errors++; $display("FAIL ur_pktcnt: got %0d expected 6", pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_caps();
        @(negedge clk);
        dq.push_back(16'd64);
        for (int i = 0; i < 8; i++) xq.push_back(64'hE0 + 64'(i));
        wait_caps(3, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_start: got %0d words expected 3", cap_data.size()); end
        #1 rst = 1'b0;
        #1;
        checks++; if ({out_vld, out_sop, out_eop, out_mod} !== 6'b0) begin errors++; $display("FAIL rm_frame: got %b expected 0", {out_vld, out_sop, out_eop, out_mod}); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rm_data: got %h expected 0", out_data); end
        checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL rm_cnt: got %0d expected 0", pkt_cnt); end
        checks++; if ({desc_rd, dat_rd, err_len} !== 3'b0) begin errors++; $display("FAIL rm_strobes: got %b expected 000", {desc_rd, dat_rd, err_len}); end
        repeat (2) @(negedge clk);
        dq.delete();
        xq.delete();
        @(posedge clk);
        #2;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({out_vld, desc_rd, dat_rd} !== 3'b0) begin errors++; $display("FAIL rm_idle: got %b expected 000", {out_vld, desc_rd, dat_rd}); end
        clear_caps();
        dq.push_back(16'd16);
        xq.push_back(64'hF0); xq.push_back(64'hF1);
        wait_caps(2, 100, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok || cap_data.size() != 2) begin errors++; $display("FAIL rm_count: got %0d expected 2", cap_data.size()); end
        if (ok) begin
            checks++; if ({cap_data[0], cap_sop[0], cap_eop[0]} !== {64'hF0, 1'b1, 1'b0}) begin errors++; $display("FAIL rm_w0: got %h/%b%b expected f0/10", cap_data[0], cap_sop[0], cap_eop[0]); end
            checks++; if ({cap_data[1], cap_sop[1], cap_eop[1]} !== {64'hF1, 1'b0, 1'b1}) begin errors++; $display("FAIL rm_w1: got %h/%b%b expected f1/01", cap_data[1], cap_sop[1], cap_eop[1]); end
        end
        checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL rm_pktcnt: got %0d expected 1", pkt_cnt); end
    endtask

    task automatic test_invariants();
        checks++; if (mod_err !== 0) begin errors++; $display("FAIL inv_mod: got %0d nonzero mod without eop expected 0", mod_err); end
        checks++; if (rd_empty_err !== 0) begin errors++; $display("FAIL inv_rd_empty: got %0d expected 0", rd_empty_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_zero_len();
        test_backpressure();
        test_underrun();
        test_reset_mid();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_ique_rd.md
# pkt_ique_rd

Read side of the packet input queue. Pops a per-packet byte-length descriptor from a descriptor FIFO and the matching data words from a data FIFO. Emits each packet as a framed stream (valid/ready, sop/eop, last-word byte count) toward the downstream parser. Sits between the queue FIFOs and the packet-processing pipeline, closing the path opened by the queue writer.

## Interface
Parameters:
- DWID, 64, data word width in bits; power of two, ≥ 16
- LWID, 16, descriptor length width (packet length in bytes)
- Derived, local: BYTES = DWID/8; MODW = log2(BYTES)

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-low reset
- desc_empty  in  1  descriptor FIFO empty; FIFO is first-word fall-through
- desc_rdata  in  LWID  head descriptor: packet length in bytes
- desc_rd  out  1  descriptor pop strobe, one cycle
- dat_empty  in  1  data FIFO empty; first-word fall-through
- dat_rdata  in  DWID  head data word
- dat_rd  out  1  data pop strobe
- out_vld  out  1  output word valid
- out_rdy  in  1  downstream ready
- out_data  out  DWID  output word
- out_sop  out  1  first word of packet
- out_eop  out  1  last word of packet
- out_mod  out  MODW  valid bytes in eop word; 0 means all BYTES valid; 0 when !out_eop
- err_len  out  1  one-cycle pulse: zero-length descriptor discarded
- pkt_cnt  out  32  packets fully sent (eop accepted); wraps at 2^32

## Operation
- FSM states: IDLE, LOAD, SEND.
- IDLE:
  - If !desc_empty, go to LOAD.
- LOAD:
  - Assert desc_rd for exactly one cycle.
  - Latch len = desc_rdata and words = (len + BYTES-1) >> MODW, computed at LWID+1 bits with no overflow.
  - Latch mod = len[MODW-1:0].
  - If len == 0, pulse err_len and go to IDLE; no data is popped.
  - Otherwise set remaining = words, first = 1, and go to SEND.
- SEND, advance condition: adv = !dat_empty && (!out_vld || out_rdy).
- SEND, on adv:
  - Assert dat_rd.
  - Load the output register: out_data = dat_rdata, out_vld = 1, out_sop = first, out_eop = (remaining == 1), out_mod = (remaining == 1) ? mod : 0.
  - Clear first; decrement remaining.
  - When remaining was 1, go to IDLE.
- Output register drain:
  - If out_vld && out_rdy and no adv in the same cycle, clear out_vld, out_sop and out_eop.
  - out_data keeps its last value.
- dat_rd is never asserted while dat_empty = 1. desc_rd is never asserted outside LOAD.
- pkt_cnt increments on every cycle with out_vld && out_rdy && out_eop.
- Output handshake: while out_vld = 1 && out_rdy = 0, out_data, out_sop, out_eop and out_mod hold stable.
- Data FIFO underrun mid-packet: stall in SEND, out_vld drops once the held word is accepted, and the packet resumes when data arrives. The packet is never truncated.
- Descriptor lengths are trusted. The data FIFO is required to hold exactly words entries per descriptor; no resync logic.

## Timing
- Reset (rst = 0), asynchronous: state = IDLE; all outputs 0, including out_data, pkt_cnt and err_len.
- Release of reset is synchronous to clk.
- Reset mid-packet aborts the packet immediately. No eop is emitted, and FIFO contents are not touched.
- Latency: desc_empty falls at cycle N (data present) → LOAD at N+1 (desc_rd high) → SEND at N+2 (dat_rd high) → out_vld = 1 with out_sop at N+3.
- Throughput: one word per cycle in SEND with out_rdy held high and data available.
- Packet gap: 2 idle output cycles between packets (eop accept → IDLE → LOAD → SEND).
- A pop and an accept of the held word may occur in the same cycle: the new word replaces the old with no bubble.
- err_len is asserted in the LOAD cycle only.
- pkt_cnt updates on the clock edge after the eop handshake.

## Test plan
- Descriptor 64, 8 data words 0x0..0x7, out_rdy = 1 → 8 consecutive out_vld; sop on word 0x0, eop on 0x7, out_mod = 0; pkt_cnt 0 → 1; first out_vld 3 cycles after desc_empty falls.
- Descriptor 1, one word 0xAA → single word with sop = eop = 1, out_mod = 1; descriptor 9 → 2 words, eop word with out_mod = 1.
- Descriptor 0 followed by descriptor 16 → err_len pulses once, no output for the first; second packet is 2 words with correct framing; pkt_cnt = 1.
- Descriptor 32, out_rdy toggling 1,0,0,1,…: each word appears exactly once, output stable while out_rdy = 0, no dat_rd issued while the held word is unaccepted; order preserved.
- Descriptor 40, data FIFO empty for 5 cycles after word 2: dat_rd stays low while empty, the packet resumes after the stall, 5 words total, eop only on the last with out_mod = 0.
- rst asserted during word 3 of 8: all outputs 0 asynchronously, FSM in IDLE; a new descriptor after release produces a correctly framed packet.
